// File: rtl/aes_avalon_pkg.sv
// Shared constants and state type for the AES Avalon-MM register initiator.
// Addresses are word addresses into the AES slave's register map.
package aes_avalon_pkg;

  localparam logic [3:0] ADDR_KEY0  = 4'd0;
  localparam logic [3:0] ADDR_MSG0  = 4'd4;
  localparam logic [3:0] ADDR_DEC0  = 4'd8;
  localparam logic [3:0] ADDR_START = 4'd14;
  localparam logic [3:0] ADDR_DONE  = 4'd15;

  typedef enum logic [3:0] {
    IDLE,
    WR_KEY,
    WR_MSG,
    WR_START,
    GAP,
    POLL,
    RD_RES,
    WR_CLR,
    RESP
  } state_e;

endpackage

// File: rtl/aes_avalon_master.sv
// Hardware replacement for the AES decrypt driver: writes key/ciphertext, starts, polls done,
// reads plaintext. Optional poll timeout is enabled with `define AES_AVALON_MASTER_TIMEOUT_EN.
module aes_avalon_master
  import aes_avalon_pkg::*;
#(
  parameter int POLL_GAP      = 4,
  parameter int TIMEOUT_POLLS = 4096
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         REQ_VALID,
  output logic         REQ_READY,
  input  logic [127:0] REQ_KEY,
  input  logic [127:0] REQ_MSG_ENC,
  output logic         RES_VALID,
  input  logic         RES_READY,
  output logic [127:0] RES_MSG_DEC,
  output logic         RES_ERR,
  output logic         BUSY,
  output logic         AVL_READ,
  output logic         AVL_WRITE,
  output logic         AVL_CS,
  output logic [3:0]   AVL_BYTE_EN,
  output logic [3:0]   AVL_ADDR,
  output logic [31:0]  AVL_WRITEDATA,
  input  logic [31:0]  AVL_READDATA
);

  if (POLL_GAP < 0 || POLL_GAP > 65535 || TIMEOUT_POLLS < 1) begin : g_bad_param
    $error("aes_avalon_master: POLL_GAP must be 0..65535 and TIMEOUT_POLLS at least 1");
  end

  localparam logic [15:0] GAP_LAST = 16'(POLL_GAP - 1);

  state_e       state_q, state_d;
  logic [1:0]   beat_q, beat_d;
  logic [15:0]  gap_q, gap_d;
  logic [127:0] key_q, key_d;
  logic [127:0] msg_q, msg_d;
  logic [127:0] res_q, res_d;
`ifdef AES_AVALON_MASTER_TIMEOUT_EN
  localparam logic [31:0] POLL_LAST = 32'(TIMEOUT_POLLS - 1);
  logic [31:0]  poll_q, poll_d;
  logic         err_q, err_d;
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      beat_q  <= '0;
      gap_q   <= '0;
      key_q   <= '0;
      msg_q   <= '0;
      res_q   <= '0;
`ifdef AES_AVALON_MASTER_TIMEOUT_EN
      poll_q  <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      gap_q   <= gap_d;
      key_q   <= key_d;
      msg_q   <= msg_d;
      res_q   <= res_d;
`ifdef AES_AVALON_MASTER_TIMEOUT_EN
      poll_q  <= poll_d;
      err_q   <= err_d;
`endif
    end
  end

  // Word w of a 128-bit operand sits at bits [(3-w)*32 +: 32]; {~beat, 5'd0} is that offset.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    gap_d   = gap_q;
    key_d   = key_q;
    msg_d   = msg_q;
    res_d   = res_q;
`ifdef AES_AVALON_MASTER_TIMEOUT_EN
    poll_d  = poll_q;
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (REQ_VALID) begin
          key_d   = REQ_KEY;
          msg_d   = REQ_MSG_ENC;
          res_d   = '0;
          beat_d  = '0;
          state_d = WR_KEY;
`ifdef AES_AVALON_MASTER_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end
      end
      WR_KEY: begin
        beat_d = beat_q + 2'd1;
        if (beat_q == 2'd3) state_d = WR_MSG;
      end
      WR_MSG: begin
        beat_d = beat_q + 2'd1;
        if (beat_q == 2'd3) state_d = WR_START;
      end
      WR_START: begin
        gap_d   = '0;
        state_d = (POLL_GAP == 0) ? POLL : GAP;
`ifdef AES_AVALON_MASTER_TIMEOUT_EN
        poll_d  = '0;
`endif
      end
      GAP: begin
        gap_d = gap_q + 16'd1;
        if (gap_q == GAP_LAST) state_d = POLL;
      end
      POLL: begin
        if (AVL_READDATA[0]) begin
          beat_d  = '0;
          state_d = RD_RES;
        end
`ifdef AES_AVALON_MASTER_TIMEOUT_EN
        else if (poll_q == POLL_LAST) begin
          err_d   = 1'b1;
          state_d = WR_CLR;
        end else begin
          poll_d = poll_q + 32'd1;
        end
`endif
      end
      RD_RES: begin
        res_d[{~beat_q, 5'd0} +: 32] = AVL_READDATA;
        beat_d = beat_q + 2'd1;
        if (beat_q == 2'd3) state_d = WR_CLR;
      end
      WR_CLR: state_d = RESP;
      RESP: begin
        if (RES_READY) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    AVL_READ      = 1'b0;
    AVL_WRITE     = 1'b0;
    AVL_ADDR      = 4'd0;
    AVL_WRITEDATA = 32'd0;
    case (state_q)
      WR_KEY: begin
        AVL_WRITE     = 1'b1;
        AVL_ADDR      = ADDR_KEY0 + {2'b00, beat_q};
        AVL_WRITEDATA = key_q[{~beat_q, 5'd0} +: 32];
      end
      WR_MSG: begin
        AVL_WRITE     = 1'b1;
        AVL_ADDR      = ADDR_MSG0 + {2'b00, beat_q};
        AVL_WRITEDATA = msg_q[{~beat_q, 5'd0} +: 32];
      end
      WR_START: begin
        AVL_WRITE     = 1'b1;
        AVL_ADDR      = ADDR_START;
        AVL_WRITEDATA = 32'h1;
      end
      POLL: begin
        AVL_READ = 1'b1;
        AVL_ADDR = ADDR_DONE;
      end
      RD_RES: begin
        AVL_READ = 1'b1;
        AVL_ADDR = ADDR_DEC0 + {2'b00, beat_q};
      end
      WR_CLR: begin
        AVL_WRITE = 1'b1;
        AVL_ADDR  = ADDR_START;
      end
      default: ;
    endcase
    AVL_CS      = AVL_READ | AVL_WRITE;
    AVL_BYTE_EN = {4{AVL_READ | AVL_WRITE}};
    REQ_READY   = (state_q == IDLE);
    BUSY        = (state_q != IDLE);
    RES_VALID   = (state_q == RESP);
    RES_MSG_DEC = res_q;
`ifdef AES_AVALON_MASTER_TIMEOUT_EN
    RES_ERR     = err_q;
`else
    RES_ERR     = 1'b0;
`endif
  end

endmodule

// File: doc/aes_avalon_master.md
Name: aes_avalon_master

Overview:
- Avalon-MM initiator that drives the AES decryption register interface from hardware, replacing the software driver.
- Accepts one key/ciphertext job on a valid/ready port and writes key words to addresses 0-3 and ciphertext words to 4-7.
- Pulses start through register 14 and polls done register 15.
- Reads the plaintext from addresses 8-11, clears start, and returns the result on a valid/ready port.
- Sits between a fabric-side job source and the AES slave's Avalon-MM port.

Parameters:
- POLL_GAP, 4: idle cycles after the start write before the first done poll; covers the slave's registered done and its one-cycle update lag.
- TIMEOUT_POLLS, 4096: number of done polls before abort; used only with the optional feature.

Ports:
- CLK  in  1  clock
- RESET  in  1  synchronous active-high reset
- REQ_VALID  in  1  job offered
- REQ_READY  out  1  block can accept a job; high only in IDLE
- REQ_KEY  in  128  AES key; [127:96] goes to address 0, [31:0] to address 3
- REQ_MSG_ENC  in  128  ciphertext; [127:96] goes to address 4, [31:0] to address 7
- RES_VALID  out  1  result available
- RES_READY  in  1  result consumed
- RES_MSG_DEC  out  128  plaintext; address 8 maps to [127:96]
- RES_ERR  out  1  poll timeout occurred
- BUSY  out  1  state is not IDLE
- AVL_READ  out  1  Avalon-MM read
- AVL_WRITE  out  1  Avalon-MM write
- AVL_CS  out  1  chip select; high exactly when AVL_READ or AVL_WRITE is high
- AVL_BYTE_EN  out  4  always 4'b1111 during a transfer, 4'b0000 otherwise
- AVL_ADDR  out  4  word address
- AVL_WRITEDATA  out  32  write data
- AVL_READDATA  in  32  read data; zero-latency, sampled on the same edge that ends the read cycle

Behaviour:
- Reset values: all AVL_* outputs 0, RES_VALID 0, RES_MSG_DEC 0, RES_ERR 0, BUSY 0, state IDLE. REQ_READY is 1 from the first cycle after reset.
- Job capture: handshake at edge E when REQ_VALID && REQ_READY. Key and message are latched internally at E, so the inputs may change afterwards.
- Every bus transfer takes one cycle; there is no waitrequest. A 2-bit beat counter sequences the four-word phases.
- State sequence and timing, relative to edge E:
  - WR_KEY: cycles 1-4, writes addresses 0..3.
  - WR_MSG: cycles 5-8, writes addresses 4..7.
  - WR_START: cycle 9, writes 32'h1 to address 14.
  - GAP: POLL_GAP cycles with no bus activity.
  - POLL: reads address 15 once per cycle until AVL_READDATA[0]=1. Upper bits are ignored.
  - RD_RES: four cycles reading addresses 8..11 into RES_MSG_DEC words 3..0.
  - WR_CLR: writes 32'h0 to address 14.
  - RESP: RES_VALID=1. RES_MSG_DEC and RES_ERR stay stable until RES_VALID && RES_READY, then the block returns to IDLE.
- Latency: best case is done seen on the first poll. With POLL_GAP=4 this gives 9+4+1+4+1 = 19 cycles from E to the RES_VALID rising edge.
- Back-to-back jobs: REQ_READY is low from E+1 until the response handshake. A new job can be captured on the cycle after the response handshake.
- RES_READY held high on entry to RESP: handshake completes on the first RESP cycle.
- Reset mid-operation: aborts at the next edge with no partial response. A start bit already written stays set in the slave; the next job's WR_START rewrites it, and the slave reset clears it.

Optional Feature:
- Macro AES_AVALON_MASTER_TIMEOUT_EN.
- Defined:
  - A poll counter counts POLL reads.
  - If TIMEOUT_POLLS reads complete without done, the block skips RD_RES, executes WR_CLR, then enters RESP with RES_ERR=1 and RES_MSG_DEC=0.
  - The counter clears on entry to POLL.
- Undefined:
  - POLL continues indefinitely.
  - RES_ERR is tied to 0 and no counter logic exists.

Decomposition:
- Package aes_avalon_pkg holds:
  - Address constants ADDR_KEY0=0, ADDR_MSG0=4, ADDR_DEC0=8, ADDR_START=14, ADDR_DONE=15.
  - The state enum typedef: IDLE, WR_KEY, WR_MSG, WR_START, GAP, POLL, RD_RES, WR_CLR, RESP.
- No sub-module; the FSM, beat counter and gap/poll counter form a single module.

Test Plan:
- Single job, slave model asserts done on the 3rd poll. Key 000102030405060708090a0b0c0d0e0f, ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a, model returns 00112233445566778899aabbccddeeff. Required:
  - Write log shows addresses 0..7 in order, with 32'h00010203 at address 0.
  - Start write, exactly POLL_GAP idle cycles, 3 reads of address 15, reads of 8..11, clear write.
  - RES_MSG_DEC = 00112233445566778899aabbccddeeff and RES_ERR=0.
- Done on the first poll with RES_READY held high: RES_VALID rises 19 cycles after E and lasts exactly 1 cycle.
- RES_READY held low for 10 cycles in RESP: RES_VALID and RES_MSG_DEC are stable, REQ_READY=0, and there is no bus activity.
- RESET asserted during WR_MSG beat 2: next cycle all AVL_* are 0 and REQ_READY=1. A following job completes normally.
- With AES_AVALON_MASTER_TIMEOUT_EN, TIMEOUT_POLLS=8 and done never set: exactly 8 polls, then the clear write, then RES_ERR=1 and RES_MSG_DEC=0.
- Two back-to-back jobs with REQ_VALID held high: the second job is captured on the cycle after the first response handshake.
